// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
// Shares one pipelined 16-bit memory port between a video fetcher and a CPU.
// Video strobes always win and go straight through combinationally. The CPU
// uses the cycles the fetcher leaves free and is acknowledged for one cycle.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   vid_adr_i/stb_i     video word address and single-cycle read strobe
//   vid_dat_o           video read data (mem_dat_i passed through)
//   cpu_adr_i/dat_i/sel_i/we_i/stb_i
//                       CPU request, held until cpu_ack_o
//   cpu_ack_o/dat_o     one-cycle acknowledge; read data valid with it
//   mem_adr_o/stb_o/we_o/sel_o/dat_o
//                       memory command, at most one per cycle
//   mem_dat_i           read data, valid RD_LAT cycles after its command
//
// Parameter RD_LAT     memory read latency, 1..7 cycles
// Macro VGA_MEM_ARB_WRBUF_EN
//                       adds a one-entry posted write buffer so CPU writes
//                       are acknowledged without waiting for a free cycle
module vga_mem_arbiter #(
    parameter int RD_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:1] vid_adr_i,
    input  logic        vid_stb_i,
    output logic [15:0] vid_dat_o,
    input  logic [17:1] cpu_adr_i,
    input  logic [15:0] cpu_dat_i,
    input  logic [1:0]  cpu_sel_i,
    input  logic        cpu_we_i,
    input  logic        cpu_stb_i,
    output logic        cpu_ack_o,
    output logic [15:0] cpu_dat_o,
    output logic [17:1] mem_adr_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    output logic [1:0]  mem_sel_o,
    output logic [15:0] mem_dat_o,
    input  logic [15:0] mem_dat_i
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_ack;
    logic [15:0] r_dat;
    logic        w_free;
    logic        w_cpu_go;

    assign w_free    = ~vid_stb_i;
    assign vid_dat_o = mem_dat_i;
    assign cpu_ack_o = r_ack;
    assign cpu_dat_o = r_dat;

`ifdef VGA_MEM_ARB_WRBUF_EN
    logic        r_wb_vld;
    logic [17:1] r_wb_adr;
    logic [15:0] r_wb_dat;
    logic [1:0]  r_wb_sel;
    logic        w_drain;
    logic        w_wb_cap;

    // Writes never issue directly; only reads do, and only once the buffer
    // is empty so a read cannot overtake a posted write.
    assign w_drain  = r_wb_vld & w_free;
    assign w_wb_cap = ~rst & (r_state == IDLE) & cpu_stb_i & cpu_we_i & ~r_wb_vld;
    assign w_cpu_go = ~rst & (r_state == IDLE) & cpu_stb_i & ~cpu_we_i & w_free & ~r_wb_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_vld <= 1'b0;
            r_wb_adr <= '0;
            r_wb_dat <= '0;
            r_wb_sel <= '0;
        end else if (w_wb_cap) begin
            r_wb_vld <= 1'b1;
            r_wb_adr <= cpu_adr_i;
            r_wb_dat <= cpu_dat_i;
            r_wb_sel <= cpu_sel_i;
        end else if (w_drain) begin
            r_wb_vld <= 1'b0;
        end
    end
`else
    // rst gates the issue so the port stays quiet during reset.
    assign w_cpu_go = ~rst & (r_state == IDLE) & cpu_stb_i & w_free;
`endif

    // Command mux: video, then buffer drain, then a fresh CPU issue.
    always_comb begin
        mem_stb_o = 1'b0;
        mem_we_o  = 1'b0;
        mem_sel_o = 2'b11;
        mem_adr_o = vid_adr_i;
        mem_dat_o = '0;
        if (vid_stb_i) begin
            mem_stb_o = 1'b1;
        end
`ifdef VGA_MEM_ARB_WRBUF_EN
        else if (w_drain) begin
            mem_stb_o = 1'b1;
            mem_we_o  = 1'b1;
            mem_sel_o = r_wb_sel;
            mem_adr_o = r_wb_adr;
            mem_dat_o = r_wb_dat;
        end
`endif
        else if (w_cpu_go) begin
            mem_stb_o = 1'b1;
            mem_we_o  = cpu_we_i;
            mem_sel_o = cpu_sel_i;
            mem_adr_o = cpu_adr_i;
            mem_dat_o = cpu_dat_i;
        end
    end

    // r_cnt is 1 in the cycle after issue, so it reaches LAT in the cycle the
    // read data is on mem_dat_i, independent of later video traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cpu_go) begin
                        if (cpu_we_i) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                            r_cnt   <= 3'd1;
                        end
                    end
`ifdef VGA_MEM_ARB_WRBUF_EN
                    else if (w_wb_cap) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
`endif
                end
                RD_WAIT: begin
                    if (r_cnt == LAT) begin
                        r_dat   <= mem_dat_i;
                        r_cnt   <= '0;
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: a table of combinational command-mux vectors,
// then cycle sequences for video latency, CPU read/write timing, stalls,
// reset mid-read and an aborted request. A small memory model answers reads
// RD_LAT cycles after each command and stores writes by byte enable.
module tb_vga_mem_arbiter;

    localparam int RD_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:1] vid_adr_i;
    logic        vid_stb_i;
    logic [15:0] vid_dat_o;
    logic [17:1] cpu_adr_i;
    logic [15:0] cpu_dat_i;
    logic [1:0]  cpu_sel_i;
    logic        cpu_we_i;
    logic        cpu_stb_i;
    logic        cpu_ack_o;
    logic [15:0] cpu_dat_o;
    logic [17:1] mem_adr_o;
    logic        mem_stb_o;
    logic        mem_we_o;
    logic [1:0]  mem_sel_o;
    logic [15:0] mem_dat_o;
    logic [15:0] mem_dat_i;

    int nchk = 0;
    int nerr = 0;

    vga_mem_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .vid_adr_i(vid_adr_i), .vid_stb_i(vid_stb_i), .vid_dat_o(vid_dat_o),
        .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_sel_i(cpu_sel_i),
        .cpu_we_i(cpu_we_i), .cpu_stb_i(cpu_stb_i), .cpu_ack_o(cpu_ack_o),
        .cpu_dat_o(cpu_dat_o),
        .mem_adr_o(mem_adr_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
        .mem_sel_o(mem_sel_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [15:0] mm [logic [16:0]];
    logic [15:0] pipe [RD_LAT];

    function automatic logic [15:0] rd(input logic [16:0] a);
        if (mm.exists(a)) return mm[a];
        return a[15:0] ^ 16'h5A00;
    endfunction

    assign mem_dat_i = pipe[RD_LAT-1];

    always @(posedge clk) begin
        logic [15:0] old;
        for (int k = RD_LAT-1; k > 0; k--) pipe[k] <= pipe[k-1];
        pipe[0] <= (mem_stb_o && !mem_we_o) ? rd(mem_adr_o) : 16'hDEAD;
        if (mem_stb_o && mem_we_o) begin
            old = rd(mem_adr_o);
            mm[mem_adr_o] = {mem_sel_o[1] ? mem_dat_o[15:8] : old[15:8],
                             mem_sel_o[0] ? mem_dat_o[7:0]  : old[7:0]};
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        vid_stb_i = 1'b0; vid_adr_i = '0;
        cpu_stb_i = 1'b0; cpu_we_i = 1'b0; cpu_adr_i = '0;
        cpu_dat_i = '0;   cpu_sel_i = 2'b11;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst, vs;
        logic [17:1] va;
        logic        cs, cw;
        logic [17:1] ca;
        logic [1:0]  csel;
        logic [15:0] cd;
        logic        es, ew;
        logic [17:1] ea;
        logic [1:0]  esel;
    } vec_t;

    vec_t tv [8];

`ifdef VGA_MEM_ARB_WRBUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    initial begin
        int ack_c, acks, iss_c, wcnt, wc, cpu_acc;
        logic [15:0] rdat;

        for (int k = 0; k < RD_LAT; k++) pipe[k] = 16'h0;
        mm[17'h00100] = 16'hA5A5;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_ack",  32'(cpu_ack_o), 32'h0);
        chk("rst_dat",  32'(cpu_dat_o), 32'h0);
        chk("rst_mstb", 32'(mem_stb_o), 32'h0);
        rst = 1'b0;

        // rst vs va cs cw ca csel cd | es ew ea esel
        tv[0] = '{1'b0, 1'b0, 17'h00ABC, 1'b0, 1'b0, 17'h0,     2'b11, 16'h0,    1'b0, 1'b0, 17'h00ABC, 2'b11};
        tv[1] = '{1'b0, 1'b1, 17'h00100, 1'b0, 1'b0, 17'h0,     2'b11, 16'h0,    1'b1, 1'b0, 17'h00100, 2'b11};
        tv[2] = '{1'b0, 1'b1, 17'h00200, 1'b1, 1'b0, 17'h00020, 2'b01, 16'h0,    1'b1, 1'b0, 17'h00200, 2'b11};
        tv[3] = '{1'b0, 1'b0, 17'h00300, 1'b1, 1'b0, 17'h00020, 2'b01, 16'h0,    1'b1, 1'b0, 17'h00020, 2'b01};
        if (BUF)
            tv[4] = '{1'b0, 1'b0, 17'h1FFFF, 1'b1, 1'b1, 17'h00040, 2'b10, 16'h1234, 1'b0, 1'b0, 17'h1FFFF, 2'b11};
        else
            tv[4] = '{1'b0, 1'b0, 17'h1FFFF, 1'b1, 1'b1, 17'h00040, 2'b10, 16'h1234, 1'b1, 1'b1, 17'h00040, 2'b10};
        tv[5] = '{1'b0, 1'b1, 17'h10001, 1'b1, 1'b1, 17'h00040, 2'b11, 16'h5555, 1'b1, 1'b0, 17'h10001, 2'b11};
        tv[6] = '{1'b1, 1'b0, 17'h00555, 1'b1, 1'b0, 17'h00020, 2'b11, 16'h0,    1'b0, 1'b0, 17'h00555, 2'b11};
        tv[7] = '{1'b1, 1'b1, 17'h00777, 1'b1, 1'b0, 17'h00020, 2'b11, 16'h0,    1'b1, 1'b0, 17'h00777, 2'b11};

        // each vector starts from a freshly reset FSM; no clock edge occurs
        // while it is applied
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            rst = tv[i].rst;
            vid_stb_i = tv[i].vs;  vid_adr_i = tv[i].va;
            cpu_stb_i = tv[i].cs;  cpu_we_i  = tv[i].cw;
            cpu_adr_i = tv[i].ca;  cpu_sel_i = tv[i].csel; cpu_dat_i = tv[i].cd;
            #1;
            chk($sformatf("vec%0d_stb", i), 32'(mem_stb_o), 32'(tv[i].es));
            chk($sformatf("vec%0d_we",  i), 32'(mem_we_o),  32'(tv[i].ew));
            chk($sformatf("vec%0d_adr", i), 32'(mem_adr_o), 32'(tv[i].ea));
            if (tv[i].es) chk($sformatf("vec%0d_sel", i), 32'(mem_sel_o), 32'(tv[i].esel));
            if (tv[i].ew) chk($sformatf("vec%0d_dat", i), 32'(mem_dat_o), 32'(tv[i].cd));
            idle_inputs();
            rst = 1'b1;
        end

        // video read: command in cycle 0, data on vid_dat_o in cycle 3
        do_reset();
        vid_stb_i = 1'b1; vid_adr_i = 17'h00100;
        #1;
        chk("vid_stb", 32'(mem_stb_o), 32'h1);
        chk("vid_adr", 32'(mem_adr_o), 32'h00100);
        step(); vid_stb_i = 1'b0;
        step(); step(); #1;
        chk("vid_dat_c3", 32'(vid_dat_o), 32'hA5A5);

        // CPU read, no video: issue cycle 0, ack cycle 4 only
        do_reset();
        cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 17'h00020; cpu_sel_i = 2'b11;
        #1;
        chk("cpurd_iss", 32'({mem_stb_o, mem_we_o, mem_adr_o}), 32'({1'b1, 1'b0, 17'h00020}));
        ack_c = -1; acks = 0; rdat = '0;
        for (int c = 1; c <= 8; c++) begin
            step(); #1;
            if (cpu_ack_o) begin
                acks++; ack_c = c; rdat = cpu_dat_o; cpu_stb_i = 1'b0;
            end
        end
        chk("cpurd_ackc", 32'(ack_c), 32'd4);
        chk("cpurd_acks", 32'(acks), 32'd1);
        chk("cpurd_dat",  32'(rdat), 32'(rd(17'h00020)));

        // reset in the middle of a read; cpu_dat_o still holds the last read
        @(negedge clk);
        cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 17'h00030;
        step(); step();
        rst = 1'b1; cpu_stb_i = 1'b0;
        #1;
        chk("rstmid_ack", 32'(cpu_ack_o), 32'h0);
        chk("rstmid_dat", 32'(cpu_dat_o), 32'h0);
        step(); rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            #1; if (cpu_ack_o) acks++;
            step();
        end
        chk("rstmid_noack", 32'(acks), 32'd0);

        // video cycles 0-3 stall a CPU read: issue 4, ack 8, video data intact
        do_reset();
        cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 17'h00020;
        ack_c = -1; acks = 0; iss_c = -1; rdat = '0;
        for (int c = 0; c <= 12; c++) begin
            vid_stb_i = (c < 4);
            vid_adr_i = 17'h00100 + 17'(c);
            #1;
            if (mem_stb_o && !vid_stb_i && mem_adr_o == 17'h00020 && iss_c < 0) iss_c = c;
            if (cpu_ack_o && !rst) begin
                acks++; ack_c = c; rdat = cpu_dat_o; cpu_stb_i = 1'b0;
            end
            if (c >= 3 && c <= 6)
                chk($sformatf("stall_vid%0d", c - 3), 32'(vid_dat_o),
                    32'(rd(17'h00100 + 17'(c - 3))));
            if (cpu_ack_o === 1'b0 && c < 8 && c > 0 && ack_c >= 0) ;
            step();
        end
        vid_stb_i = 1'b0;
        chk("stall_iss",  32'(iss_c), 32'd4);
        chk("stall_ackc", 32'(ack_c), 32'd8);
        chk("stall_acks", 32'(acks), 32'd1);
        chk("stall_dat",  32'(rdat), 32'(rd(17'h00020)));

        // CPU write under video cycles 0-2, then read back
        do_reset();
        cpu_stb_i = 1'b1; cpu_we_i = 1'b1; cpu_adr_i = 17'h00040;
        cpu_dat_i = 16'h1234; cpu_sel_i = 2'b11;
        ack_c = -1; wcnt = 0; wc = -1;
        for (int c = 0; c <= 10; c++) begin
            vid_stb_i = (c < 3);
            vid_adr_i = 17'h00200 + 17'(c);
            #1;
            if (mem_stb_o && mem_we_o) begin wcnt++; wc = c; end
            if (cpu_ack_o) begin ack_c = c; cpu_stb_i = 1'b0; cpu_we_i = 1'b0; end
            step();
        end
        vid_stb_i = 1'b0;
        chk("wr_ackc", 32'(ack_c), BUF ? 32'd1 : 32'd4);
        chk("wr_memc", 32'(wc), 32'd3);
        chk("wr_cnt",  32'(wcnt), 32'd1);
        cpu_stb_i = 1'b1; cpu_we_i = 1'b0; cpu_adr_i = 17'h00040;
        rdat = '0; acks = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (cpu_ack_o) begin acks++; rdat = cpu_dat_o; cpu_stb_i = 1'b0; end
            step();
        end
        chk("wr_rb_acks", 32'(acks), 32'd1);
        chk("wr_rb_dat",  32'(rdat), 32'h1234);

        // request raised in cycle 0, dropped in cycle 1, video busy: aborted
        do_reset();
        cpu_stb_i = 1'b1; cpu_we_i = ~BUF; cpu_adr_i = 17'h00060; cpu_dat_i = 16'hBEEF;
        acks = 0; wcnt = 0; cpu_acc = 0;
        for (int c = 0; c <= 8; c++) begin
            if (c == 1) cpu_stb_i = 1'b0;
            vid_stb_i = (c < 4);
            vid_adr_i = 17'h00300 + 17'(c);
            #1;
            if (mem_we_o) wcnt++;
            if (mem_stb_o && !vid_stb_i) cpu_acc++;
            if (cpu_ack_o) acks++;
            step();
        end
        chk("abort_we",  32'(wcnt), 32'd0);
        chk("abort_mem", 32'(cpu_acc), 32'd0);
        chk("abort_ack", 32'(acks), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 3: memory read latency in cycles (legal range 1..7).
REQ-002 SHALL have port clk  in  1  (the single clock; all state on its rising edge).
REQ-003 SHALL have port rst  in  1  (reset, asynchronous, active-high).
REQ-004 SHALL have port vid_adr_i  in  17  [17:1], video fetch word address.
REQ-005 SHALL have port vid_stb_i  in  1  (single-cycle video read strobe; never stalled).
REQ-006 SHALL have port vid_dat_o  out  16  (read data to the video fetcher).
REQ-007 SHALL have port cpu_adr_i  in  17  [17:1], CPU word address.
REQ-008 SHALL have port cpu_dat_i  in  16  (CPU write data).
REQ-009 SHALL have port cpu_sel_i  in  2  (CPU byte enables).
REQ-010 SHALL have port cpu_we_i  in  1  (CPU write = 1, read = 0).
REQ-011 SHALL have port cpu_stb_i  in  1  (CPU request, held until ack).
REQ-012 SHALL have port cpu_ack_o  out  1  (one-cycle acknowledge).
REQ-013 SHALL have port cpu_dat_o  out  16  (CPU read data, valid with ack).
REQ-014 SHALL have ports mem_adr_o  out  17; mem_stb_o  out  1; mem_we_o  out  1; mem_sel_o  out  2; mem_dat_o  out  16 (pipelined memory command, one per cycle).
REQ-015 SHALL have port mem_dat_i  in  16 (read data valid exactly RD_LAT cycles after the command cycle).

Function
REQ-016 Video priority: when vid_stb_i=1, the module SHALL issue mem_stb_o=1, mem_we_o=0, mem_sel_o=2'b11, mem_adr_o=vid_adr_i in the same cycle, combinationally.
REQ-017 vid_dat_o SHALL equal mem_dat_i combinationally; the fetcher samples it RD_LAT cycles after its strobe.
REQ-018 CPU slot: a cycle with vid_stb_i=0 is free; the CPU command SHALL drive mem_* only in a free cycle.
REQ-019 FSM states SHALL be IDLE, RD_WAIT and ACK.
REQ-020 IDLE with cpu_stb_i=1 in a free cycle SHALL issue the CPU command; a read SHALL go to RD_WAIT, and a write SHALL go to ACK.
REQ-021 RD_WAIT SHALL count RD_LAT cycles from the issue cycle t and capture mem_dat_i into cpu_dat_o at the end of cycle t+RD_LAT.
REQ-022 After that capture, RD_WAIT SHALL go to ACK.
REQ-023 In ACK, cpu_ack_o SHALL be 1 for exactly one cycle and no CPU command SHALL issue; ACK SHALL then return to IDLE.
REQ-024 Read-ack latency SHALL be RD_LAT+1 cycles after issue when unstalled; write-ack latency SHALL be 1 cycle.
REQ-025 Video strobes during RD_WAIT SHALL issue normally; in-flight CPU read data SHALL be selected by the issue-cycle count, not by vid_stb_i.
REQ-026 A CPU request pending in non-free cycles SHALL wait with no timeout; cpu_ack_o SHALL stay 0 while it waits.
REQ-027 Idle outputs SHALL be mem_stb_o=0, mem_we_o=0 and mem_adr_o=vid_adr_i.
REQ-028 cpu_stb_i dropped before issue SHALL abort the request with no memory access and no ack.

Reset
REQ-029 rst=1 SHALL immediately set FSM=IDLE, cpu_ack_o=0, cpu_dat_o=16'h0, latency counter=0 and write buffer empty.
REQ-030 A read or buffered write in flight at reset SHALL be discarded, with no ack after release.
REQ-031 mem_stb_o SHALL be 0 during reset unless vid_stb_i=1.

Configuration
REQ-032 Macro VGA_MEM_ARB_WRBUF_EN SHALL select the posted-write option.
REQ-033 With VGA_MEM_ARB_WRBUF_EN defined, a one-entry posted write buffer SHALL exist.
REQ-034 With the buffer, a CPU write in IDLE with the buffer empty SHALL be captured, go to ACK next cycle, and issue to memory in the first later free cycle.
REQ-035 A write arriving with the buffer full SHALL wait until the buffer drains.
REQ-036 A CPU read SHALL issue only after the buffer drains (read-after-write order).
REQ-037 A buffer drain SHALL take priority over a new CPU issue in the same free cycle.
REQ-038 Without VGA_MEM_ARB_WRBUF_EN, writes SHALL issue directly per REQ-020 and no buffer logic SHALL be present.

Verification
REQ-039 RD_LAT=3: vid_stb_i=1, vid_adr_i=17'h00100 at cycle 0 -> mem_stb_o=1, mem_adr_o=17'h00100 in cycle 0; model data 16'hA5A5 appears on vid_dat_o at cycle 3.
REQ-040 CPU read of 17'h00020 at cycle 0 with no video -> issue cycle 0, cpu_dat_o=model data, cpu_ack_o=1 in cycle 4 only.
REQ-041 vid_stb_i high cycles 0-3, CPU read from cycle 0 -> CPU issue cycle 4, ack cycle 8; all 4 video reads return correct data.
REQ-042 Buffer on: CPU write 16'h1234 to 17'h00040 during continuous video -> ack cycle 1; memory write in first free cycle; following read of 17'h00040 returns 16'h1234.
REQ-043 rst asserted mid-RD_WAIT (cycle 2) -> cpu_ack_o=0, cpu_dat_o=0 immediately; no ack after release.
REQ-044 cpu_stb_i raised then dropped at cycle 1 while video busy -> no mem_we_o, no cpu_ack_o.
